panel_io_ctrl: RTL and testbench

PANEL_IO_CTRL -- requirements
Module: panel_io_ctrl

---
 rtl/panel_io_pkg.sv | 18 +
 rtl/panel_debounce.sv | 55 +++++
 rtl/panel_io_ctrl.sv | 124 ++++++++++++
 tb/tb_panel_io_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/panel_io_pkg.sv
// Shared types and default sizing for the front-panel I/O controller.
package panel_io_pkg;

  localparam int unsigned N_BTN_DEF     = 4;
  localparam int unsigned N_LED_DEF     = 8;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned CNT_W_DEF     = 8;
  localparam int unsigned DEB_CNT_DEF   = 1000;
  localparam int unsigned BLINK_DIV_DEF = 4800000;

  typedef enum logic [1:0] {
    LED_DIRECT = 2'd0,
    LED_BLINK  = 2'd1,
    LED_MIRROR = 2'd2,
    LED_OFF    = 2'd3
  } led_mode_t;

endpackage

// File: rtl/panel_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and press pulse.
module panel_debounce
  import panel_io_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEB_CNT_DEF
) (
  input  logic ti_clk,
  input  logic reset,
  input  logic button_n,
  output logic btn_state,
  output logic press_pulse
);

  localparam int unsigned DW = $clog2(DEB_CNT);

  if (DEB_CNT < 2) begin : g_bad_deb
    $error("DEB_CNT must be >= 2");
  end

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_cnt;
  logic          r_state;
  logic          r_pulse;

  // Inverting ahead of the first flop keeps the reset value (0) equal to the idle level.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= ~button_n;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_state) begin
        if (r_cnt == DW'(DEB_CNT - 1)) begin
          r_state <= r_sync2;
          r_pulse <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_state   = r_state;
  assign press_pulse = r_pulse;

endmodule

// File: rtl/panel_io_ctrl.sv
// Front-panel I/O: debounced buttons with press counters, LED driver, registered adder.
// Build macro PANEL_IO_BLINK_EN enables the blink prescaler; without it blink mode equals direct mode.
module panel_io_ctrl
  import panel_io_pkg::*;
#(
  parameter int unsigned N_BTN     = N_BTN_DEF,
  parameter int unsigned N_LED     = N_LED_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DEB_CNT   = DEB_CNT_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic                   ti_clk,
  input  logic                   reset,
  input  logic [N_BTN-1:0]       button_n,
  output logic [N_LED-1:0]       led_n,
  input  logic [N_LED-1:0]       led_pat,
  input  logic [1:0]             led_mode,
  input  logic                   clr_cnt,
  input  logic [DATA_W-1:0]      op_a,
  input  logic [DATA_W-1:0]      op_b,
  output logic [N_BTN-1:0]       btn_state,
  output logic [N_BTN-1:0]       press_pulse,
  output logic [N_BTN*CNT_W-1:0] press_cnt,
  output logic [DATA_W-1:0]      sum,
  output logic                   carry
);

  localparam int unsigned SUM_W = DATA_W + 1;

  if (N_LED < N_BTN) begin : g_bad_led
    $error("N_LED must be >= N_BTN");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("BLINK_DIV must be >= 2");
  end

  logic [N_BTN-1:0]  w_btn_state;
  logic [N_BTN-1:0]  w_press_pulse;
  logic [N_LED-1:0]  w_mirror;
  logic [N_LED-1:0]  w_led_nxt;
  logic              w_phase;
  logic [N_LED-1:0]  r_led_n;
  logic [DATA_W-1:0] r_sum;
  logic              r_carry;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;

    panel_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .ti_clk      (ti_clk),
      .reset       (reset),
      .button_n    (button_n[i]),
      .btn_state   (w_btn_state[i]),
      .press_pulse (w_press_pulse[i])
    );

    // Clear has priority over a coincident press.
    always_ff @(posedge ti_clk) begin
      if (reset || clr_cnt) begin
        r_cnt <= '0;
      end else if (w_press_pulse[i]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign press_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end

`ifdef PANEL_IO_BLINK_EN
  localparam int unsigned PW = $clog2(BLINK_DIV);

  logic [PW-1:0] r_presc;
  logic          r_phase;

  // Free-running half-period timer; mode changes never disturb it.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      r_presc <= '0;
      r_phase <= 1'b1;
    end else if (r_presc == PW'(BLINK_DIV - 1)) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_phase = r_phase;
`else
  assign w_phase = 1'b1;
`endif

  always_comb begin
    w_mirror              = '1;
    w_mirror[N_BTN-1:0]   = ~w_btn_state;
    w_led_nxt             = '1;
    case (led_mode_t'(led_mode))
      LED_DIRECT: w_led_nxt = ~led_pat;
      LED_BLINK:  w_led_nxt = ~(led_pat & {N_LED{w_phase}});
      LED_MIRROR: w_led_nxt = w_mirror;
      LED_OFF:    w_led_nxt = '1;
      default:    w_led_nxt = '1;
    endcase
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      r_led_n <= '1;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_led_n          <= w_led_nxt;
      {r_carry, r_sum} <= SUM_W'(op_a) + SUM_W'(op_b);
    end
  end

  assign led_n       = r_led_n;
  assign btn_state   = w_btn_state;
  assign press_pulse = w_press_pulse;
  assign sum         = r_sum;
  assign carry       = r_carry;

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Self-checking bench for panel_io_ctrl (DEB_CNT=4, BLINK_DIV=8), directed plus randomized steps.
module tb_panel_io_ctrl;

  localparam int unsigned N_BTN     = 4;
  localparam int unsigned N_LED     = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DEB_CNT   = 4;
  localparam int unsigned BLINK_DIV = 8;

  logic                   ti_clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N_BTN-1:0]       button_n = '1;
  logic [N_LED-1:0]       led_n;
  logic [N_LED-1:0]       led_pat = '0;
  logic [1:0]             led_mode = 2'd3;
  logic                   clr_cnt = 1'b0;
  logic [DATA_W-1:0]      op_a = '0;
  logic [DATA_W-1:0]      op_b = '0;
  logic [N_BTN-1:0]       btn_state;
  logic [N_BTN-1:0]       press_pulse;
  logic [N_BTN*CNT_W-1:0] press_cnt;
  logic [DATA_W-1:0]      sum;
  logic                   carry;

  int checks = 0;
  int failures = 0;
  int m_edges = 0;
  int m_cnt [N_BTN];

  panel_io_ctrl #(
    .N_BTN(N_BTN), .N_LED(N_LED), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .DEB_CNT(DEB_CNT), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .ti_clk(ti_clk), .reset(reset), .button_n(button_n), .led_n(led_n),
    .led_pat(led_pat), .led_mode(led_mode), .clr_cnt(clr_cnt),
    .op_a(op_a), .op_b(op_b), .btn_state(btn_state), .press_pulse(press_pulse),
    .press_cnt(press_cnt), .sum(sum), .carry(carry)
  );

  always #5 ti_clk = ~ti_clk;

  // Edges since the last reset edge; blink phase is derived from this count arithmetically.
  always @(posedge ti_clk) begin
    if (reset) m_edges <= 0;
    else       m_edges <= m_edges + 1;
  end

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_LED-1:0] exp_led(input logic [1:0] mode, input logic [N_LED-1:0] pat,
                                               input int edges, input logic [N_BTN-1:0] btn);
    logic ph;
    logic [N_LED-1:0] mir;
    ph = (((edges - 1) / BLINK_DIV) % 2) == 0;
    mir = '1;
    mir[N_BTN-1:0] = ~btn;
    case (mode)
      2'd0: return ~pat;
`ifdef PANEL_IO_BLINK_EN
      2'd1: return ph ? ~pat : '1;
`else
      2'd1: return ~pat;
`endif
      2'd2: return mir;
      default: return '1;
    endcase
  endfunction

  function automatic logic [N_BTN*CNT_W-1:0] exp_cnt();
    logic [N_BTN*CNT_W-1:0] v;
    for (int i = 0; i < N_BTN; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  // Hold button ch low for len cycles, release for 12 cycles; return pulses seen on ch.
  task automatic press_ch(input int ch, input int len, output int npulse);
    npulse = 0;
    button_n[ch] = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (press_pulse[ch]) npulse++;
    end
    button_n[ch] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (press_pulse[ch]) npulse++;
    end
  endtask

  initial begin
    int np;
    int ch;
    int len;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W:0] s;
    for (int i = 0; i < N_BTN; i++) m_cnt[i] = 0;

    // Reset state
    tick(); tick(); tick();
    check("rst_led_n", 64'(led_n), 64'hFF);
    check("rst_btn_state", 64'(btn_state), 64'h0);
    check("rst_press_pulse", 64'(press_pulse), 64'h0);
    check("rst_press_cnt", 64'(press_cnt), 64'h0);
    check("rst_sum_carry", 64'({carry, sum}), 64'h0);
    reset = 1'b0;

    // Adder: directed corners then random operands
    op_a = 16'hFFFF; op_b = 16'h0001; tick();
    check("add_wrap", 64'({carry, sum}), 64'h1_0000);
    op_a = 16'h1234; op_b = 16'h0101; tick();
    check("add_plain", 64'({carry, sum}), 64'h0_1335);
    for (int i = 0; i < 20; i++) begin
      a = DATA_W'($urandom); b = DATA_W'($urandom);
      op_a = a; op_b = b; tick();
      s = {1'b0, a} + {1'b0, b};
      check("add_rand", 64'({carry, sum}), 64'(s));
    end

    // LEDs: off, direct, blink run, then random mode/pattern
    led_pat = 8'hA5; led_mode = 2'd3; tick();
    check("led_off", 64'(led_n), 64'hFF);
    led_mode = 2'd0; tick();
    check("led_direct", 64'(led_n), 64'h5A);
    led_mode = 2'd1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("led_blink", 64'(led_n), 64'(exp_led(2'd1, 8'hA5, m_edges, '0)));
    end
    led_mode = 2'd3; tick();
    check("led_off_after_blink", 64'(led_n), 64'hFF);
    for (int i = 0; i < 40; i++) begin
      led_pat = N_LED'($urandom); led_mode = 2'($urandom); tick();
      check("led_rand", 64'(led_n), 64'(exp_led(led_mode, led_pat, m_edges, '0)));
    end

    // Held press on ch0: accepted DEB_CNT+2 cycles after the edge, single pulse
    button_n[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("ch0_state", 64'(btn_state[0]), 64'(i >= DEB_CNT + 2));
      check("ch0_pulse", 64'(press_pulse[0]), 64'(i == DEB_CNT + 2));
    end
    m_cnt[0] = 1;
    check("ch0_cnt", 64'(press_cnt), 64'(exp_cnt()));
    led_mode = 2'd2; tick();
    check("led_mirror", 64'(led_n), 64'hFE);
    np = 0;
    button_n[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (press_pulse[0]) np++;
    end
    check("ch0_release_nopulse", 64'(np), 64'd0);
    check("ch0_released", 64'(btn_state[0]), 64'd0);

    // Glitch of DEB_CNT-1 cycles on ch1 is rejected
    button_n[1] = 1'b0;
    tick(); tick(); tick();
    button_n[1] = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (press_pulse[1] || btn_state[1]) np++;
    end
    check("ch1_glitch", 64'(np), 64'd0);
    check("ch1_cnt", 64'(press_cnt), 64'(exp_cnt()));

    // 256 presses on ch2 wrap the counter
    for (int i = 0; i < 256; i++) begin
      press_ch(2, 6, np);
      if (np == 1) m_cnt[2] = (m_cnt[2] + 1) % (1 << CNT_W);
      if (i == 254) check("ch2_cnt_255", 64'(press_cnt[2*CNT_W +: CNT_W]), 64'd255);
    end
    check("ch2_cnt_wrap", 64'(press_cnt[2*CNT_W +: CNT_W]), 64'd0);

    // Clear coincident with a press leaves zero
    press_ch(2, 6, np);
    m_cnt[2] = (m_cnt[2] + np) % (1 << CNT_W);
    check("ch2_cnt_one", 64'(press_cnt), 64'(exp_cnt()));
    button_n[2] = 1'b0;
    for (int i = 0; i < DEB_CNT + 2; i++) tick();
    check("ch2_pulse_for_clr", 64'(press_pulse[2]), 64'd1);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    for (int i = 0; i < N_BTN; i++) m_cnt[i] = 0;
    check("clr_wins", 64'(press_cnt), 64'h0);
    button_n[2] = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Random hold lengths across channels, straddling the DEB_CNT threshold
    for (int i = 0; i < 24; i++) begin
      ch = int'($urandom_range(0, N_BTN - 1));
      len = int'($urandom_range(1, 8));
      press_ch(ch, len, np);
      check("rand_pulses", 64'(np), 64'(len >= int'(DEB_CNT)));
      if (len >= int'(DEB_CNT)) m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CNT_W);
      check("rand_cnt", 64'(press_cnt), 64'(exp_cnt()));
    end

    // Reset two cycles into a debounce: pending change dropped, re-accepted after release
    button_n[3] = 1'b0;
    np = 0;
    tick(); if (press_pulse[3]) np++;
    tick(); if (press_pulse[3]) np++;
    reset = 1'b1; tick(); if (press_pulse[3]) np++;
    reset = 1'b0;
    check("rst_mid_nopulse", 64'(np), 64'd0);
    for (int i = 0; i < N_BTN; i++) m_cnt[i] = 0;
    check("rst_mid_cnt", 64'(press_cnt), 64'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rst_mid_pulse", 64'(press_pulse[3]), 64'(i == DEB_CNT + 2));
    end
    m_cnt[3] = 1;
    check("rst_mid_cnt_after", 64'(press_cnt), 64'(exp_cnt()));
    button_n[3] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("final_btn_state", 64'(btn_state), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
